// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, memory request handshake and
// an in-order instruction queue feeding decode, with jump flush support.
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [INST_W-1:0]        mem_rdata_i,
  input  logic                     jump_flag_i,
  input  logic [ADDR_W-1:0]        jump_addr_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [INST_W-1:0]        id_inst_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q [DEPTH];
  logic [ADDR_W-1:0] epc_d [DEPTH];
  logic [INST_W-1:0] einst_q [DEPTH];
  logic [INST_W-1:0] einst_d [DEPTH];
  logic [DEPTH-1:0]  efill_q, efill_d;
  ptr_t head_q, head_d;
  ptr_t alloc_q, alloc_d;
  ptr_t fill_q, fill_d;
  cnt_t cnt_q, cnt_d;
  cnt_t pend_q, pend_d;
  cnt_t drop_q, drop_d;

  logic grant, pop, resp_ok, credit;

  // drop_q slots stay reserved until memory pays back wrong-path responses
  assign credit = ({1'b0, cnt_q} + {1'b0, drop_q}) < {1'b0, DEPTH_C};
  assign mem_req_o = !rst && !jump_flag_i && credit;
  assign mem_addr_o = pc_q;

  assign id_valid_o = efill_q[head_q] && (cnt_q != '0) && !jump_flag_i;
  assign id_inst_o = einst_q[head_q];
  assign id_pc_o = epc_q[head_q];
  assign occupancy_o = cnt_q;

  assign grant = mem_req_o && mem_gnt_i;
  assign pop = id_valid_o && id_ready_i;
  assign resp_ok = mem_rvalid_i && ((pend_q != '0) || (drop_q != '0));

  always_comb begin
    pc_d = pc_q;
    epc_d = epc_q;
    einst_d = einst_q;
    efill_d = efill_q;
    head_d = head_q;
    alloc_d = alloc_q;
    fill_d = fill_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    drop_d = drop_q;
    if (jump_flag_i) begin
      pc_d = jump_addr_i;
      head_d = '0;
      alloc_d = '0;
      fill_d = '0;
      cnt_d = '0;
      pend_d = '0;
      drop_d = drop_q + pend_q - cnt_t'(resp_ok);
    end else begin
      if (grant) begin
        epc_d[alloc_q] = pc_q;
        efill_d[alloc_q] = 1'b0;
        alloc_d = alloc_q + ptr_t'(1);
        pc_d = pc_q + PC_STEP;
      end
      if (resp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - cnt_t'(1);
        end else begin
          einst_d[fill_q] = mem_rdata_i;
          efill_d[fill_q] = 1'b1;
          fill_d = fill_q + ptr_t'(1);
        end
      end
      if (pop) begin
        head_d = head_q + ptr_t'(1);
      end
      cnt_d = cnt_q + cnt_t'(grant) - cnt_t'(pop);
      pend_d = pend_q + cnt_t'(grant)
             - cnt_t'(resp_ok && (drop_q == '0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        epc_q[i] <= '0;
        einst_q[i] <= '0;
      end
      efill_q <= '0;
      head_q <= '0;
      alloc_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      epc_q <= epc_d;
      einst_q <= einst_d;
      efill_q <= efill_d;
      head_q <= head_d;
      alloc_q <= alloc_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: in-order memory model with fixed
// latency, expected PCs queued by stimulus and checked by a monitor.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic [2:0]  occupancy_o;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_inst, w_pc;
  logic [2:0]  w_occ;

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
    .occupancy_o(occupancy_o)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .mem_req_o(w_req), .mem_addr_o(w_addr),
    .mem_gnt_i(1'b1), .mem_rvalid_i(1'b0),
    .mem_rdata_i(32'h0),
    .jump_flag_i(1'b0), .jump_addr_i(32'h0),
    .id_valid_o(w_valid), .id_ready_i(1'b0),
    .id_inst_o(w_inst), .id_pc_o(w_pc),
    .occupancy_o(w_occ)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] exp_pc[$];
  logic [31:0] wexp [4];

  function automatic logic [31:0] minst(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  task automatic settle();
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = minst(q_addr[0]);
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
    end
    #1;
  endtask

  task automatic clock();
    if (mem_req_o && mem_gnt_i) begin
      q_addr.push_back(mem_addr_o);
      q_due.push_back(cyc + lat);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    q_addr.delete();
    q_due.delete();
    exp_pc.delete();
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_gnt_i = 1'b0;
    id_ready_i = 1'b0;
    jump_flag_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_valid", id_valid_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_pc", id_pc_o, 0);
    chk("rst_inst", id_inst_o, 0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic drain();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_pc.size() == 0) break;
      settle();
      clock();
    end
    chk("drain_left", exp_pc.size(), 0);
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expectation
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (!rst && id_valid_o && id_ready_i) begin
      checks++;
      if (exp_pc.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc %h expected none", id_pc_o);
      end else begin
        e = exp_pc.pop_front();
        if (id_pc_o !== e || id_inst_o !== minst(e)) begin
          errors++;
          $display("FAIL pop: got pc %h inst %h expected pc %h inst %h",
                   id_pc_o, id_inst_o, e, minst(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    wexp[3] = 32'h0000_0004;
    @(negedge clk);
    #1;

    // sequential fetch, plus wrap instance
    do_reset();
    lat = 1;
    id_ready_i = 1'b1;
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) exp_pc.push_back(32'(i * 4));
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("seq_req", mem_req_o, 1);
      chk("seq_addr", mem_addr_o, 32'(k * 4));
      chk("seq_valid", id_valid_o, 32'(k >= 2));
      if (k < 5) chk("wrap_req", w_req, 32'(k < 4));
      if (k < 4) chk("wrap_addr", w_addr, wexp[k]);
      clock();
    end
    drain();

    // backpressure
    do_reset();
    lat = 1;
    id_ready_i = 1'b0;
    mem_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("bp_req", mem_req_o, 1);
      chk("bp_addr", mem_addr_o, 32'(k * 4));
      clock();
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_full_req", mem_req_o, 0);
      chk("bp_full_occ", occupancy_o, 4);
      chk("bp_head_pc", id_pc_o, 0);
      clock();
    end
    for (int i = 0; i < 5; i++) exp_pc.push_back(32'(i * 4));
    id_ready_i = 1'b1;
    settle();
    chk("bp_pop_req", mem_req_o, 0);
    clock();
    settle();
    chk("bp_resume_req", mem_req_o, 1);
    chk("bp_resume_addr", mem_addr_o, 32'h10);
    clock();
    drain();

    // jump with two requests in flight
    do_reset();
    lat = 3;
    id_ready_i = 1'b1;
    mem_gnt_i = 1'b1;
    settle(); clock();
    settle(); clock();
    mem_gnt_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    settle();
    chk("j_req", mem_req_o, 0);
    clock();
    jump_flag_i = 1'b0;
    mem_gnt_i = 1'b1;
    exp_pc.push_back(32'h100);
    settle();
    chk("j_req_tgt", mem_req_o, 1);
    chk("j_addr", mem_addr_o, 32'h100);
    chk("j_valid3", id_valid_o, 0);
    clock();
    mem_gnt_i = 1'b0;
    for (int c = 4; c < 8; c++) begin
      settle();
      chk("j_valid", id_valid_o, 32'(c == 7));
      if (c == 7) chk("j_pc", id_pc_o, 32'h100);
      clock();
    end
    drain();

    // jump coinciding with a response
    do_reset();
    lat = 2;
    id_ready_i = 1'b1;
    mem_gnt_i = 1'b1;
    settle(); clock();
    settle(); clock();
    mem_gnt_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h200;
    settle();
    chk("sj_req", mem_req_o, 0);
    clock();
    jump_flag_i = 1'b0;
    mem_gnt_i = 1'b1;
    exp_pc.push_back(32'h200);
    settle();
    chk("sj_addr", mem_addr_o, 32'h200);
    chk("sj_occ", occupancy_o, 0);
    clock();
    mem_gnt_i = 1'b0;
    settle();
    chk("sj_valid4", id_valid_o, 0);
    clock();
    drain();

    // asynchronous reset mid-operation
    do_reset();
    lat = 1;
    id_ready_i = 1'b0;
    mem_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle(); clock();
    end
    mem_gnt_i = 1'b0;
    id_ready_i = 1'b1;
    exp_pc.push_back(32'h0);
    settle(); clock();
    id_ready_i = 1'b0;
    settle();
    chk("mo_occ", occupancy_o, 3);
    chk("mo_pc", id_pc_o, 32'h4);
    rst = 1'b1;
    #1;
    chk("mo_rst_req", mem_req_o, 0);
    chk("mo_rst_valid", id_valid_o, 0);
    chk("mo_rst_occ", occupancy_o, 0);
    chk("mo_rst_pc", id_pc_o, 0);
    chk("mo_rst_inst", id_inst_o, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    mem_gnt_i = 1'b1;
    id_ready_i = 1'b1;
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    settle();
    chk("mo_restart_req", mem_req_o, 1);
    chk("mo_restart_addr", mem_addr_o, 32'h0);
    clock();
    settle();
    chk("mo_restart_addr1", mem_addr_o, 32'h4);
    clock();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
